// File: rtl/december_sat_top_if.sv
// Control/data bundle between the WalkSAT controller and the december_sat_top datapath.
// The slave modport is the datapath side; the master modport is the controller side.
interface december_sat_top_if #(
  parameter int NSAT                      = 3,
  parameter int NUM_VARIABLES             = 2048,
  parameter int MAX_CLAUSE_MEMBERSHIP     = 20,
  parameter int UNSAT_CLAUSE_BUFFER_DEPTH = 2048,
  parameter int CONTROLLER_SIGNAL_WIDTH   = 14
);
  localparam int LIT_W   = $clog2(NUM_VARIABLES) + 1;
  localparam int CL_W    = NSAT * LIT_W;
  localparam int UCNT_W  = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH) + 1;
  localparam int OCC_W   = $clog2(MAX_CLAUSE_MEMBERSHIP + 1);

  logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_signal_i;
  logic [CL_W-1:0]                    clause_i;
  logic                               clause_sat_o;
  logic [LIT_W-1:0]                   fifo_data_o;
  logic                               fifo_empty_o;
  logic                               fifo_full_o;
  logic                               ucb_empty_o;
  logic                               ucb_full_o;
  logic [UCNT_W-1:0]                  ucb_count_o;
  logic [OCC_W-1:0]                   occ_cnt_o;
  logic [31:0]                        flip_count_o;

  modport slave (
    input  control_signal_i, clause_i,
    output clause_sat_o, fifo_data_o, fifo_empty_o, fifo_full_o,
           ucb_empty_o, ucb_full_o, ucb_count_o, occ_cnt_o, flip_count_o
  );

  modport master (
    output control_signal_i, clause_i,
    input  clause_sat_o, fifo_data_o, fifo_empty_o, fifo_full_o,
           ucb_empty_o, ucb_full_o, ucb_count_o, occ_cnt_o, flip_count_o
  );
endinterface

// File: rtl/december_sat_top.sv
// WalkSAT datapath: clause register, variable table, candidate FIFO and unsat-clause buffer.
// Optional flip counter enabled by defining FLIP_COUNTER_EN.
module december_sat_clause_register #(
  parameter int W = 36
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);
  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)       data_q <= '0;
    else if (load_i) data_q <= data_i;
  end

  assign data_o = data_q;
endmodule

module december_sat_top #(
  parameter int NSAT                      = 3,
  parameter int NUM_VARIABLES             = 2048,
  parameter int MAX_CLAUSE_MEMBERSHIP     = 20,
  parameter int FIFO_DEPTH                = 32,
  parameter int UNSAT_CLAUSE_BUFFER_DEPTH = 2048,
  parameter int CONTROLLER_SIGNAL_WIDTH   = 14
) (
  input  logic                clk_i,
  input  logic                rst_i,
  december_sat_top_if.slave   bus
);
  localparam int LIT_W  = $clog2(NUM_VARIABLES) + 1;
  localparam int IDX_W  = LIT_W - 1;
  localparam int CL_W   = NSAT * LIT_W;
  localparam int FPTR_W = $clog2(FIFO_DEPTH);
  localparam int UPTR_W = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH);
  localparam int OCC_W  = $clog2(MAX_CLAUSE_MEMBERSHIP + 1);

  // Control word decode
  logic       cr_wr_en, vt_en, vt_wr_en, ucb_push, ucb_pop, cr_src_sel;
  logic [1:0] lit_sel, fifo_op;

  assign cr_wr_en   = bus.control_signal_i[0];
  assign vt_en      = bus.control_signal_i[1];
  assign lit_sel    = bus.control_signal_i[3:2];
  assign vt_wr_en   = bus.control_signal_i[4];
  assign fifo_op    = bus.control_signal_i[6:5];
  assign ucb_push   = bus.control_signal_i[7];
  assign ucb_pop    = bus.control_signal_i[8];
  assign cr_src_sel = bus.control_signal_i[9];

  logic [CL_W-1:0] cr_data, cr_load_data, ucb_head;
  logic            ucb_empty;

  assign cr_load_data = cr_src_sel ? ucb_head : bus.clause_i;

  december_sat_clause_register #(.W(CL_W)) clause_register (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (cr_wr_en),
    .data_i (cr_load_data),
    .data_o (cr_data)
  );

  logic [LIT_W-1:0] lit [NSAT];
  for (genvar g = 0; g < NSAT; g++) begin : g_lit
    assign lit[g] = cr_data[g*LIT_W +: LIT_W];
  end

  logic [NUM_VARIABLES-1:0] vt_q;
  logic [LIT_W-1:0]         sel_lit;
  logic                     lit_valid, eval_sat;
  logic [IDX_W-1:0]         sel_idx;

  always_comb begin
    lit_valid = 1'b0;
    sel_lit   = '0;
    eval_sat  = 1'b0;
    for (int i = 0; i < NSAT; i++) begin
      if (lit_sel == 2'(i)) begin
        lit_valid = 1'b1;
        sel_lit   = lit[i];
      end
      eval_sat = eval_sat | (vt_q[lit[i][IDX_W-1:0]] ^ lit[i][LIT_W-1]);
    end
  end

  assign sel_idx = sel_lit[IDX_W-1:0];

  logic flip_acc;
  assign flip_acc = vt_en & vt_wr_en & lit_valid;

  logic clause_sat_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vt_q         <= '0;
      clause_sat_q <= 1'b0;
    end else begin
      if (flip_acc) vt_q[sel_idx] <= ~vt_q[sel_idx];
      if (vt_en)    clause_sat_q  <= eval_sat;
    end
  end
  assign bus.clause_sat_o = clause_sat_q;

  // Candidate-variable FIFO with saturating occurrence counter
  logic [LIT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [FPTR_W-1:0] f_wr_q, f_rd_q;
  logic [FPTR_W:0]   f_cnt_q;
  logic [OCC_W-1:0]  occ_q;
  logic              f_empty, f_full, f_push, f_pop, f_clr;

  assign f_empty = (f_cnt_q == '0);
  assign f_full  = (f_cnt_q == (FPTR_W+1)'(FIFO_DEPTH));
  assign f_push  = (fifo_op == 2'b01) & lit_valid & ~f_full;
  assign f_pop   = (fifo_op == 2'b10) & ~f_empty;
  assign f_clr   = (fifo_op == 2'b11);

  always_ff @(posedge clk_i) begin
    if (!rst_i && f_push) fifo_mem[f_wr_q] <= {1'b0, sel_idx};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || f_clr) begin
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      f_cnt_q <= '0;
      occ_q   <= '0;
    end else begin
      if (f_push) begin
        f_wr_q  <= f_wr_q + 1'b1;
        f_cnt_q <= f_cnt_q + 1'b1;
        if (occ_q != OCC_W'(MAX_CLAUSE_MEMBERSHIP)) occ_q <= occ_q + 1'b1;
      end else if (f_pop) begin
        f_rd_q  <= f_rd_q + 1'b1;
        f_cnt_q <= f_cnt_q - 1'b1;
      end
    end
  end

  assign bus.fifo_data_o  = f_empty ? '0 : fifo_mem[f_rd_q];
  assign bus.fifo_empty_o = f_empty;
  assign bus.fifo_full_o  = f_full;
  assign bus.occ_cnt_o    = occ_q;

  // Unsat-clause buffer; only clauses that evaluate unsat this cycle are stored
  logic [CL_W-1:0]   ucb_mem [UNSAT_CLAUSE_BUFFER_DEPTH];
  logic [UPTR_W-1:0] u_wr_q, u_rd_q;
  logic [UPTR_W:0]   u_cnt_q, u_cnt_d;
  logic              ucb_full, u_push, u_pop;

  assign ucb_empty = (u_cnt_q == '0);
  assign ucb_full  = (u_cnt_q == (UPTR_W+1)'(UNSAT_CLAUSE_BUFFER_DEPTH));
  assign u_push    = ucb_push & ~eval_sat & ~ucb_full;
  assign u_pop     = ucb_pop & ~ucb_empty;
  assign ucb_head  = ucb_empty ? '0 : ucb_mem[u_rd_q];

  always_comb begin
    u_cnt_d = u_cnt_q;
    if (u_push && !u_pop)      u_cnt_d = u_cnt_q + 1'b1;
    else if (u_pop && !u_push) u_cnt_d = u_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && u_push) ucb_mem[u_wr_q] <= cr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      u_wr_q  <= '0;
      u_rd_q  <= '0;
      u_cnt_q <= '0;
    end else begin
      if (u_push) u_wr_q <= u_wr_q + 1'b1;
      if (u_pop)  u_rd_q <= u_rd_q + 1'b1;
      u_cnt_q <= u_cnt_d;
    end
  end

  assign bus.ucb_empty_o = ucb_empty;
  assign bus.ucb_full_o  = ucb_full;
  assign bus.ucb_count_o = u_cnt_q;

`ifdef FLIP_COUNTER_EN
  logic [31:0] flip_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)         flip_cnt_q <= '0;
    else if (flip_acc) flip_cnt_q <= flip_cnt_q + 1'b1;
  end
  assign bus.flip_count_o = flip_cnt_q;
`else
  assign bus.flip_count_o = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{bus.control_signal_i[CONTROLLER_SIGNAL_WIDTH-1:10], sel_lit[LIT_W-1]};
endmodule

// File: tb/tb_december_sat_top.sv
// Directed bench for december_sat_top: reset, decode, eval/flip, unsat buffer, FIFO, flip counter.
module tb_december_sat_top;
  localparam int LIT_W = 12;
  localparam int CL_W  = 36;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  december_sat_top_if bus_if ();

  december_sat_top dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

`ifdef FLIP_COUNTER_EN
  localparam logic [31:0] EXP_FLIPS = 32'd3;
  localparam logic [31:0] EXP_FLIP1 = 32'd1;
`else
  localparam logic [31:0] EXP_FLIPS = 32'd0;
  localparam logic [31:0] EXP_FLIP1 = 32'd0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] cw(input bit cr, input bit vten, input logic [1:0] ls,
                                     input bit vtwr, input logic [1:0] fop, input bit up,
                                     input bit upop, input bit src);
    return {4'b0000, src, upop, up, fop, vtwr, ls, vten, cr};
  endfunction

  task automatic cyc(input logic [13:0] c, input logic [CL_W-1:0] cl);
    bus_if.control_signal_i = c;
    bus_if.clause_i         = cl;
    @(posedge clk_i);
    #1;
    bus_if.control_signal_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus_if.control_signal_i = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  logic [CL_W-1:0] c567, c_neg6, c_a, c_b, c_f;
  logic [13:0]     w_load, w_eval, w_push_u;

  initial begin
    c567   = {12'd7, 12'd6, 12'd5};
    c_neg6 = {12'd8, 12'd7, 12'h806};
    c_a    = {12'd3, 12'd2, 12'd1};
    c_b    = {12'd11, 12'd10, 12'd9};
    c_f    = {12'd7, 12'd6, 12'h805};
    w_load   = cw(1, 0, 2'd0, 0, 2'b00, 0, 0, 0);
    w_eval   = cw(0, 1, 2'd0, 0, 2'b00, 0, 0, 0);
    w_push_u = cw(0, 0, 2'd0, 0, 2'b00, 1, 0, 0);
    bus_if.control_signal_i = '0;
    bus_if.clause_i         = '0;

    // Reset
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_eq("rst_clause", dut.clause_register.data_o, 0);
    check_eq("rst_fifo_empty", bus_if.fifo_empty_o, 1);
    check_eq("rst_ucb_empty", bus_if.ucb_empty_o, 1);
    check_eq("rst_sat", bus_if.clause_sat_o, 0);
    check_eq("rst_ucb_cnt", bus_if.ucb_count_o, 0);
    check_eq("rst_flips", bus_if.flip_count_o, 0);

    // Decode: load from empty ucb, push zero clause (unsat), pop on empty ignored
    bus_if.control_signal_i = 14'b10_00_1_1_1_00_1_00_1_1;
    #1;
    check_eq("dec_cr_wr_en", dut.cr_wr_en, 1);
    check_eq("dec_vt_en", dut.vt_en, 1);
    check_eq("dec_vt_wr_en", dut.vt_wr_en, 1);
    check_eq("dec_fifo_op", dut.fifo_op, 0);
    @(posedge clk_i);
    #1;
    bus_if.control_signal_i = '0;
    check_eq("dec_clause", dut.clause_register.data_o, 0);
    check_eq("dec_ucb_cnt", bus_if.ucb_count_o, 1);
    check_eq("dec_sat", bus_if.clause_sat_o, 0);
    check_eq("dec_flips", bus_if.flip_count_o, EXP_FLIP1);
    do_reset();

    // Evaluation and flip
    cyc(w_load, c567);
    check_eq("ev_clause", dut.clause_register.data_o, c567);
    cyc(w_eval, '0);
    check_eq("ev_unsat", bus_if.clause_sat_o, 0);
    cyc(cw(0, 1, 2'd1, 1, 2'b00, 0, 0, 0), '0);
    check_eq("ev_preflip", bus_if.clause_sat_o, 0);
    cyc(w_eval, '0);
    check_eq("ev_sat", bus_if.clause_sat_o, 1);
    cyc('0, '0);
    check_eq("ev_hold", bus_if.clause_sat_o, 1);
    cyc(w_load, c_neg6);
    cyc(w_eval, '0);
    check_eq("ev_neg", bus_if.clause_sat_o, 0);
    do_reset();

    // Unsat buffer
    cyc(w_load, c_a);
    cyc(w_push_u, '0);
    check_eq("ucb_push1", bus_if.ucb_count_o, 1);
    cyc(cw(0, 1, 2'd0, 1, 2'b00, 0, 0, 0), '0);
    cyc(w_push_u, '0);
    check_eq("ucb_sat_push", bus_if.ucb_count_o, 1);
    cyc(w_load, c_b);
    cyc(cw(1, 0, 2'd0, 0, 2'b00, 0, 1, 1), c_b);
    check_eq("ucb_reload", dut.clause_register.data_o, c_a);
    check_eq("ucb_empty", bus_if.ucb_empty_o, 1);
    cyc(w_load, c_b);
    cyc(w_push_u, '0);
    check_eq("ucb_push_b", bus_if.ucb_count_o, 1);
    cyc(cw(0, 0, 2'd0, 0, 2'b00, 1, 1, 0), '0);
    check_eq("ucb_pushpop", bus_if.ucb_count_o, 1);
    cyc(w_load, c_a);
    cyc(cw(1, 0, 2'd0, 0, 2'b00, 0, 1, 1), '0);
    check_eq("ucb_reload_b", dut.clause_register.data_o, c_b);
    check_eq("ucb_cnt0", bus_if.ucb_count_o, 0);
    do_reset();

    // FIFO
    cyc(w_load, c_f);
    cyc(cw(0, 0, 2'd3, 0, 2'b01, 0, 0, 0), '0);
    check_eq("ff_noop_push", bus_if.fifo_empty_o, 1);
    cyc(cw(0, 0, 2'd0, 0, 2'b10, 0, 0, 0), '0);
    check_eq("ff_pop_empty", bus_if.fifo_empty_o, 1);
    cyc(cw(0, 0, 2'd0, 0, 2'b01, 0, 0, 0), '0);
    check_eq("ff_head", bus_if.fifo_data_o, 5);
    check_eq("ff_occ1", bus_if.occ_cnt_o, 1);
    for (int i = 0; i < 31; i++) cyc(cw(0, 0, 2'd0, 0, 2'b01, 0, 0, 0), '0);
    check_eq("ff_full", bus_if.fifo_full_o, 1);
    cyc(cw(0, 0, 2'd1, 0, 2'b01, 0, 0, 0), '0);
    check_eq("ff_full33", bus_if.fifo_full_o, 1);
    check_eq("ff_occ_sat", bus_if.occ_cnt_o, 20);
    check_eq("ff_drop", bus_if.fifo_data_o, 5);
    cyc(cw(0, 0, 2'd0, 0, 2'b10, 0, 0, 0), '0);
    check_eq("ff_pop_notfull", bus_if.fifo_full_o, 0);
    cyc(cw(0, 0, 2'd0, 0, 2'b11, 0, 0, 0), '0);
    check_eq("ff_clr_empty", bus_if.fifo_empty_o, 1);
    check_eq("ff_clr_occ", bus_if.occ_cnt_o, 0);
    check_eq("ff_clr_data", bus_if.fifo_data_o, 0);
    cyc(cw(0, 0, 2'd2, 0, 2'b01, 0, 0, 0), '0);
    check_eq("ff_head7", bus_if.fifo_data_o, 7);
    do_reset();

    // Flip counter
    cyc(w_load, c567);
    for (int i = 0; i < 3; i++) cyc(cw(0, 1, 2'(i), 1, 2'b00, 0, 0, 0), '0);
    cyc(cw(0, 1, 2'd3, 1, 2'b00, 0, 0, 0), '0);
    cyc(cw(0, 0, 2'd0, 1, 2'b00, 0, 0, 0), '0);
    check_eq("flip_count", bus_if.flip_count_o, EXP_FLIPS);
    cyc(w_eval, '0);
    check_eq("flip_sat", bus_if.clause_sat_o, 1);

    // Reset overrides control on the same edge
    rst_i = 1'b1;
    cyc(cw(1, 1, 2'd0, 1, 2'b01, 1, 0, 0), c567);
    check_eq("rstov_clause", dut.clause_register.data_o, 0);
    check_eq("rstov_fifo", bus_if.fifo_empty_o, 1);
    check_eq("rstov_sat", bus_if.clause_sat_o, 0);
    rst_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/december_sat_top.md
Name: december_sat_top

Overview:
- Datapath top of the FPGA WalkSAT engine, driven cycle by cycle by a 14-bit control word from an external controller.
- Holds one NSAT-literal clause register and a NUM_VARIABLES-bit assignment table.
- Contains a candidate-variable FIFO and an unsat-clause buffer.
- Evaluates the current clause against the assignment and flips variables on command.

Parameters:
- NSAT, 3, literals per clause; 1..4.
- NUM_VARIABLES, 2048, variable count. LIT_W = $clog2(NUM_VARIABLES)+1; a literal is {sign, index}, sign=1 means negated.
- MAX_CLAUSE_MEMBERSHIP, 20, saturation value of the occurrence counter.
- FIFO_DEPTH, 32, candidate FIFO depth in LIT_W-bit entries; power of 2.
- UNSAT_CLAUSE_BUFFER_DEPTH, 2048, unsat buffer depth in NSAT*LIT_W-bit entries; power of 2.
- CONTROLLER_SIGNAL_WIDTH, 14, control word width; must be >=14; bits above 13 ignored.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- control_signal_i  in  CONTROLLER_SIGNAL_WIDTH  control word.
- clause_i  in  NSAT*LIT_W  external clause load data.
- clause_sat_o  out  1  registered evaluation result.
- fifo_data_o  out  LIT_W  FIFO head.
- fifo_empty_o / fifo_full_o  out  1 each  FIFO status.
- ucb_empty_o / ucb_full_o  out  1 each  unsat buffer status.
- ucb_count_o  out  $clog2(UNSAT_CLAUSE_BUFFER_DEPTH)+1  unsat buffer occupancy.
- occ_cnt_o  out  $clog2(MAX_CLAUSE_MEMBERSHIP+1)  occurrence counter.
- flip_count_o  out  32  flip counter (see Optional Feature).

Behaviour:
- Control decode is purely combinational into internal nets with these exact names (hierarchically probed):
  - [0] cr_wr_en
  - [1] vt_en
  - [3:2] lit_sel (literal slot; a value >= NSAT means no-op for vt write and FIFO push)
  - [4] vt_wr_en
  - [6:5] fifo_op: 00 none, 01 push, 10 pop, 11 clear
  - [7] ucb push
  - [8] ucb pop
  - [9] cr_src_sel: 0 = clause_i, 1 = ucb head
  - [13:10] reserved, ignored
- Clause register: submodule instance named clause_register with output data_o (NSAT*LIT_W).
  - Reset -> 0.
  - cr_wr_en loads the source selected by cr_src_sel at the next edge.
  - Loading from an empty ucb loads 0.
- Variable table: NUM_VARIABLES x 1 bit, reset -> all 0.
  - Write (toggle) occurs only when vt_en & vt_wr_en & lit_sel<NSAT: flips the variable at the index of the selected literal.
- Evaluation: when vt_en, clause_sat_o <= OR over literals of (var[idx] ^ sign), using pre-flip table and current clause_register.data_o; otherwise it holds. Reset -> 0. Latency 1 cycle.
- FIFO:
  - Push writes the index field of the selected literal; push while full is dropped.
  - Pop while empty is ignored; clear empties the FIFO.
  - fifo_data_o shows the head combinationally; 0 when empty.
  - Reset -> empty.
- Occurrence counter: +1 per accepted push, saturates at MAX_CLAUSE_MEMBERSHIP, cleared by clear or reset.
- Unsat buffer:
  - Push stores clause_register.data_o only if the same-cycle combinational evaluation is unsat; push while full is dropped.
  - Pop while empty is ignored.
  - Simultaneous push+pop on a non-empty buffer keeps the count, both succeed.
  - Simultaneous cr load from ucb and ucb pop loads the pre-pop head.
  - Pointers wrap modulo depth.
  - Reset -> empty, count 0.
- Reset mid-operation overrides all control and restores every reset value on that edge.

Optional Feature:
- Macro FLIP_COUNTER_EN.
- Defined: flip_count_o increments on every accepted variable flip, wraps at 2^32, reset -> 0.
- Undefined: no counter logic; flip_count_o tied to 0.

Test Plan:
- Reset: rst_i=1 two cycles, release, one cycle -> clause_register.data_o==0, fifo_empty_o=1, ucb_empty_o=1, clause_sat_o=0.
- Decode: control_signal_i=14'b10_00_1_1_1_00_1_00_1_1 -> same cycle cr_wr_en=1, vt_en=1, vt_wr_en=1; next edge clause_register.data_o=0 (ucb empty).
- Eval/flip: load clause {+5,+6,+7} via clause_i with table all 0 -> clause_sat_o=0. Flip var 6 with lit_sel=1 -> next eval clause_sat_o=1.
- Unsat buffer: with an unsat clause loaded, ucb push -> ucb_count_o=1. Make clause sat, push -> count stays 1. Reload from ucb with pop -> data_o equals first clause, ucb_empty_o=1.
- FIFO: 33 pushes -> fifo_full_o=1, occ_cnt_o=20, 33rd dropped. Clear -> fifo_empty_o=1, occ_cnt_o=0.
- FLIP_COUNTER_EN: 3 flips -> flip_count_o=3; without macro -> 0.
